// File: rtl/uart_rx_frame_timer.sv
// Oversampling bit/frame timing generator for the UART receive path.
// Define UART_RX_TRIPLE_SAMPLE_EN for three samples per bit (majority voting); default is one centre sample.
module uart_rx_frame_timer #(
    parameter int PRESCALE_W = 6,
    parameter int DATA_BITS  = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Enable,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  Parity_EN,
    input  logic                  Stop2_EN,
    output logic [PRESCALE_W-1:0] Edge_count,
    output logic [3:0]            Bit_count,
    output logic                  Sample_strobe,
    output logic [1:0]            Sample_idx,
    output logic                  Bit_done,
    output logic                  Frame_done,
    output logic                  Busy,
    output logic                  Cfg_err,
    output logic [1:0]            State_dbg
);

    // Handshake: Enable is a level request from the RX FSM. It is honoured only
    // from IDLE; Busy is high for exactly the frame's bit periods; after Frame_done
    // the block parks in DONE until Enable falls. Enable low always aborts to IDLE.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [PRESCALE_W-1:0] ONE_P = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(4);

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic [3:0]            bit_q, bit_d;
    logic                  par_q, par_d;
    logic                  stop2_q, stop2_d;
    logic                  cfg_err_q, cfg_err_d;

    logic [3:0]            frame_len;
    logic [PRESCALE_W-1:0] center;
    logic                  last_edge;
    logic                  last_bit;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= ST_IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            p_q       <= '0;
            par_q     <= 1'b0;
            stop2_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            p_q       <= p_d;
            par_q     <= par_d;
            stop2_q   <= stop2_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Frame length uses only the configuration captured at frame start.
    assign frame_len = 4'(1 + DATA_BITS) + {3'b000, par_q} + (stop2_q ? 4'd2 : 4'd1);
    assign center    = p_q >> 1;
    assign last_edge = (edge_q == p_q - ONE_P);
    assign last_bit  = (bit_q == frame_len - 4'd1);

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        p_d       = p_q;
        par_d     = par_q;
        stop2_d   = stop2_q;
        cfg_err_d = cfg_err_q;
        if (!Enable) begin
            state_d = ST_IDLE;
            edge_d  = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    edge_d = '0;
                    bit_d  = '0;
                    if (Prescale >= P_MIN) begin
                        state_d = ST_RUN;
                        p_d     = Prescale;
                        par_d   = Parity_EN;
                        stop2_d = Stop2_EN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (last_edge) begin
                        edge_d = '0;
                        if (last_bit) begin
                            state_d = ST_DONE;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        edge_d = edge_q + ONE_P;
                    end
                end
                ST_DONE: begin
                    edge_d = '0;
                    bit_d  = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    assign Busy       = (state_q == ST_RUN);
    assign Bit_done   = Busy && last_edge;
    assign Frame_done = Bit_done && last_bit;
    assign Edge_count = edge_q;
    assign Bit_count  = bit_q;
    assign Cfg_err    = cfg_err_q;
    assign State_dbg  = state_q;

`ifdef UART_RX_TRIPLE_SAMPLE_EN
    // P>=4 keeps centre-1 and centre+1 inside the bit period.
    always_comb begin
        Sample_strobe = 1'b0;
        Sample_idx    = 2'd0;
        if (Busy) begin
            if (edge_q == center - ONE_P) begin
                Sample_strobe = 1'b1;
                Sample_idx    = 2'd0;
            end else if (edge_q == center) begin
                Sample_strobe = 1'b1;
                Sample_idx    = 2'd1;
            end else if (edge_q == center + ONE_P) begin
                Sample_strobe = 1'b1;
                Sample_idx    = 2'd2;
            end
        end
    end
`else
    assign Sample_strobe = Busy && (edge_q == center);
    assign Sample_idx    = 2'd0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Self-checking bench for uart_rx_frame_timer: directed scenarios plus random frames
// against a cycle-indexed reference model (frame position t, bit = t/P, edge = t%P).
module tb_uart_rx_frame_timer;

    localparam int PW = 6;
    localparam int DB = 8;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          Enable = 1'b0;
    logic [PW-1:0] Prescale = PW'(8);
    logic          Parity_EN = 1'b0;
    logic          Stop2_EN = 1'b0;
    logic [PW-1:0] Edge_count;
    logic [3:0]    Bit_count;
    logic          Sample_strobe;
    logic [1:0]    Sample_idx;
    logic          Bit_done;
    logic          Frame_done;
    logic          Busy;
    logic          Cfg_err;
    logic [1:0]    State_dbg;

    uart_rx_frame_timer #(.PRESCALE_W(PW), .DATA_BITS(DB)) dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .Prescale(Prescale),
        .Parity_EN(Parity_EN), .Stop2_EN(Stop2_EN),
        .Edge_count(Edge_count), .Bit_count(Bit_count),
        .Sample_strobe(Sample_strobe), .Sample_idx(Sample_idx),
        .Bit_done(Bit_done), .Frame_done(Frame_done), .Busy(Busy),
        .Cfg_err(Cfg_err), .State_dbg(State_dbg)
    );

    // Clock / reset
    always #5 Clk = ~Clk;

    // Scoreboard
    typedef struct packed {
        logic [1:0]    st;
        logic          cfg;
        logic          fd;
        logic          bd;
        logic [1:0]    idx;
        logic          strb;
        logic [3:0]    e_bit;
        logic [PW-1:0] e_edge;
        logic          busy;
    } exp_t;
    localparam int W = $bits(exp_t);
    logic [W-1:0] exp_q[$];

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference model: 0 idle, 1 run, 2 done; t is the cycle index within the frame
    int m_state = 0;
    int m_t = 0;
    int m_p = 0;
    int m_n = 0;
    bit m_cfg = 1'b0;

    task automatic model_step();
        if (!Enable) begin
            m_state = 0;
            m_t = 0;
        end else if (m_state == 0) begin
            if (int'(Prescale) >= 4) begin
                m_state = 1;
                m_t = 0;
                m_p = int'(Prescale);
                m_n = 1 + DB + int'(Parity_EN) + (Stop2_EN ? 2 : 1);
            end else begin
                m_cfg = 1'b1;
            end
        end else if (m_state == 1) begin
            if (m_t == m_n * m_p - 1) begin
                m_state = 2;
                m_t = 0;
            end else begin
                m_t++;
            end
        end
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        int ed;
        int c;
        e = '0;
        e.st = 2'(m_state);
        e.cfg = m_cfg;
        if (m_state == 1) begin
            ed = m_t % m_p;
            c = m_p / 2;
            e.busy = 1'b1;
            e.e_edge = PW'(ed);
            e.e_bit = 4'(m_t / m_p);
            e.bd = (ed == m_p - 1);
            e.fd = (m_t == m_n * m_p - 1);
`ifdef UART_RX_TRIPLE_SAMPLE_EN
            if (ed >= c - 1 && ed <= c + 1) begin
                e.strb = 1'b1;
                e.idx = 2'(ed - (c - 1));
            end
`else
            e.strb = (ed == c);
`endif
        end
        return e;
    endfunction

    task automatic compare_outputs();
        exp_t e;
        e = exp_t'(exp_q.pop_front());
        check_eq("busy", 32'(Busy), 32'(e.busy));
        check_eq("edge_count", 32'(Edge_count), 32'(e.e_edge));
        check_eq("bit_count", 32'(Bit_count), 32'(e.e_bit));
        check_eq("sample_strobe", 32'(Sample_strobe), 32'(e.strb));
        check_eq("sample_idx", 32'(Sample_idx), 32'(e.idx));
        check_eq("bit_done", 32'(Bit_done), 32'(e.bd));
        check_eq("frame_done", 32'(Frame_done), 32'(e.fd));
        check_eq("cfg_err", 32'(Cfg_err), 32'(e.cfg));
        check_eq("state", 32'(State_dbg), 32'(e.st));
    endtask

    // Drivers: inputs change only at negedge, model advances at posedge
    task automatic tick();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        exp_q.push_back(model_expect());
        compare_outputs();
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        check_eq("rst_busy", 32'(Busy), 0);
        check_eq("rst_edge", 32'(Edge_count), 0);
        check_eq("rst_bit", 32'(Bit_count), 0);
        check_eq("rst_strobe", 32'(Sample_strobe), 0);
        check_eq("rst_idx", 32'(Sample_idx), 0);
        check_eq("rst_bd", 32'(Bit_done), 0);
        check_eq("rst_fd", 32'(Frame_done), 0);
        check_eq("rst_cfg", 32'(Cfg_err), 0);
        check_eq("rst_state", 32'(State_dbg), 0);
        m_state = 0;
        m_t = 0;
        m_cfg = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic start(input int p, input bit par, input bit st2);
        Prescale = PW'(p);
        Parity_EN = par;
        Stop2_EN = st2;
        Enable = 1'b1;
    endtask

    // Runs ticks until Frame_done is seen (plus one) or the budget expires
    task automatic run_frame(input int budget, output int bd_cnt, output int fd_at);
        bd_cnt = 0;
        fd_at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (Bit_done) bd_cnt++;
            if (Frame_done && fd_at < 0) fd_at = i;
            else if (fd_at >= 0) break;
        end
    endtask

    initial begin
        int bd_cnt;
        int fd_at;
        int fd_seen;
        int len;

        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        tick();
        check_eq("idle_after_reset", 32'(Busy), 0);

        // P=8, N=10
        start(8, 1'b0, 1'b0);
        run_frame(200, bd_cnt, fd_at);
        check_eq("p8_bit_done_count", 32'(bd_cnt), 10);
        check_eq("p8_frame_done_cycle", 32'(fd_at), 79);
        repeat (3) tick();
        Enable = 1'b0;
        tick();

        // P=5, parity, 2 stop bits: N=12
        start(5, 1'b1, 1'b1);
        run_frame(200, bd_cnt, fd_at);
        check_eq("p5_bit_done_count", 32'(bd_cnt), 12);
        check_eq("p5_frame_done_cycle", 32'(fd_at), 59);
        repeat (5) tick();
        check_eq("p5_done_hold", 32'(State_dbg), 2);
        Enable = 1'b0;
        tick();
        check_eq("p5_back_idle", 32'(State_dbg), 0);

        // Abort at bit 4, edge 2
        start(8, 1'b0, 1'b0);
        fd_seen = 0;
        repeat (35) begin
            tick();
            if (Frame_done) fd_seen++;
        end
        check_eq("abort_pre_bit", 32'(Bit_count), 4);
        check_eq("abort_pre_edge", 32'(Edge_count), 2);
        Enable = 1'b0;
        tick();
        if (Frame_done) fd_seen++;
        check_eq("abort_no_frame_done", 32'(fd_seen), 0);
        Enable = 1'b1;
        run_frame(200, bd_cnt, fd_at);
        check_eq("after_abort_frame_cycle", 32'(fd_at), 79);
        Enable = 1'b0;
        tick();

        // Config changes during RUN are ignored until the next frame
        start(8, 1'b0, 1'b0);
        repeat (10) tick();
        Prescale = PW'(16);
        Parity_EN = 1'b1;
        run_frame(200, bd_cnt, fd_at);
        check_eq("cfg_hold_frame_cycle", 32'(fd_at + 10), 79);
        Enable = 1'b0;
        tick();
        Enable = 1'b1;
        run_frame(300, bd_cnt, fd_at);
        check_eq("p16_frame_done_cycle", 32'(fd_at), 175);
        check_eq("p16_bit_done_count", 32'(bd_cnt), 11);
        Enable = 1'b0;
        tick();

        // Illegal prescale sets sticky Cfg_err
        start(3, 1'b0, 1'b0);
        repeat (3) tick();
        check_eq("cfg_err_set", 32'(Cfg_err), 1);
        check_eq("cfg_err_not_busy", 32'(Busy), 0);
        Enable = 1'b0;
        tick();
        start(8, 1'b0, 1'b0);
        repeat (20) tick();
        check_eq("cfg_err_sticky", 32'(Cfg_err), 1);

        // Reset mid-frame
        apply_reset();
        tick();
        check_eq("cfg_err_cleared", 32'(Cfg_err), 0);
        Enable = 1'b0;
        tick();

        // Random frames with mid-frame input changes, aborts and resets
        for (int it = 0; it < 40; it++) begin
            start($urandom_range(3, 10), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            len = $urandom_range(1, 150);
            for (int k = 0; k < len; k++) begin
                tick();
                if ($urandom_range(0, 15) == 0) Prescale = PW'($urandom_range(3, 20));
                if ($urandom_range(0, 15) == 0) Parity_EN = ~Parity_EN;
                if ($urandom_range(0, 15) == 0) Stop2_EN = ~Stop2_EN;
            end
            Enable = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            if ($urandom_range(0, 7) == 0) apply_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
